pc_branch_unit: RTL and testbench

- Parametrised successor to the combinational branch-offset lookup. Owns the program counter register and a run/halt state machine.
- Computes the next PC from one of three sources: sequential increment, sign-extended immediate offset, or an entry of a runtime-writable offset LUT.
- Sits between instruction decode (branch controls) and instruction memory (fetch address).

---
 rtl/pc_branch_unit_pkg.sv | 19 +
 rtl/pc_branch_unit_lut.sv | 44 ++++
 rtl/pc_branch_unit.sv | 164 ++++++++++++++++
 tb/tb_pc_branch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared types and helpers for the program-counter / branch unit.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_RESET = '0;

  // Sign-extend the low w bits of v to 32 bits; callers truncate to their width.
  function automatic logic signed [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] t;
    t = $signed(v << (32 - w));
    return t >>> (32 - w);
  endfunction

endpackage

// File: rtl/pc_branch_unit_lut.sv
// Runtime-writable branch-offset table; reads are combinational and return 0
// for any index at or beyond LUT_DEPTH.
module pc_offset_lut
  import pc_pkg::*;
#(
  parameter int D         = 12,
  parameter int SEL_W     = 4,
  parameter int LUT_DEPTH = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [SEL_W-1:0] waddr,
  input  logic [D-1:0]     wdata,
  input  logic [SEL_W-1:0] raddr,
  output logic [D-1:0]     rdata
);

  localparam int LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

  logic [D-1:0] mem_q [LUT_DEPTH];
  logic [D-1:0] mem_d [LUT_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (int'(waddr) < LUT_DEPTH)) begin
      mem_d[waddr[LUT_AW-1:0]] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the registered contents, so a same-cycle write is not visible.
  assign rdata = (int'(raddr) < LUT_DEPTH) ? mem_q[raddr[LUT_AW-1:0]] : '0;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with run/halt control and immediate/LUT branch offsets.
// Define PC_RAS_EN to add a circular return-address stack for call/ret.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int D         = 12,
  parameter int SEL_W     = 4,
  parameter int LUT_DEPTH = 2 ** SEL_W,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [D-1:0]     start_addr,
  input  logic             halt,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             use_lut,
  input  logic [SEL_W-1:0] sel,
  input  logic             lut_we,
  input  logic [SEL_W-1:0] lut_waddr,
  input  logic [D-1:0]     lut_wdata,
  input  logic             call,
  input  logic             ret,
  output logic [D-1:0]     pc,
  output logic             running,
  output logic             done,
  output logic             ras_err
);

  pc_state_t state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] lut_rdata;
  logic signed [D-1:0] offset;
  logic [D-1:0] pc_inc, pc_tgt;

  pc_offset_lut #(
    .D         (D),
    .SEL_W     (SEL_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (sel),
    .rdata (lut_rdata)
  );

  assign offset = use_lut ? $signed(lut_rdata) : D'(sext(32'(sel), SEL_W));
  assign pc_inc = pc_q + D'(1);
  assign pc_tgt = pc_q + $unsigned(offset);

`ifdef PC_RAS_EN
  localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [D-1:0]    ras_q [RAS_DEPTH];
  logic [D-1:0]    ras_d [RAS_DEPTH];
  logic [RAS_AW-1:0] tp_q, tp_d;   // slot the next push writes
  logic [RAS_AW:0]   cnt_q, cnt_d;
  logic [RAS_AW-1:0] tp_prev, tp_next;
  logic            ras_err_q, ras_err_d;

  assign tp_prev = (tp_q == '0) ? RAS_AW'(RAS_DEPTH - 1) : tp_q - RAS_AW'(1);
  assign tp_next = (tp_q == RAS_AW'(RAS_DEPTH - 1)) ? '0 : tp_q + RAS_AW'(1);
  assign ras_err = ras_err_q;
`else
  logic unused_ret;
  assign unused_ret = ret;
  assign ras_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_RAS_EN
    ras_d     = ras_q;
    tp_d      = tp_q;
    cnt_d     = cnt_q;
    ras_err_d = ras_err_q;
`endif
    // start has top priority from every state
    if (start) begin
      pc_d    = start_addr;
      state_d = RUN;
`ifdef PC_RAS_EN
      ras_err_d = 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (halt) begin
            state_d = HALTED;
          end else if (stall) begin
            pc_d = pc_q;
`ifdef PC_RAS_EN
          end else if (ret) begin
            if (cnt_q == '0) begin
              pc_d      = pc_inc;
              ras_err_d = 1'b1;
            end else begin
              pc_d  = ras_q[tp_prev];
              tp_d  = tp_prev;
              cnt_d = cnt_q - (RAS_AW + 1)'(1);
            end
`endif
          end else if (branch_en || call) begin
            pc_d = pc_tgt;
`ifdef PC_RAS_EN
            if (call) begin
              ras_d[tp_q] = pc_inc;
              tp_d        = tp_next;
              // a full stack overwrites its oldest entry
              if (cnt_q == (RAS_AW + 1)'(RAS_DEPTH)) begin
                ras_err_d = 1'b1;
              end else begin
                cnt_d = cnt_q + (RAS_AW + 1)'(1);
              end
            end
`endif
          end else begin
            pc_d = pc_inc;
          end
        end
        IDLE, HALTED: begin
          pc_d = pc_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= D'(PC_RESET);
`ifdef PC_RAS_EN
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
      tp_q      <= '0;
      cnt_q     <= '0;
      ras_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_RAS_EN
      ras_q     <= ras_d;
      tp_q      <= tp_d;
      cnt_q     <= cnt_d;
      ras_err_q <= ras_err_d;
`endif
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == HALTED);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed scoreboard bench for pc_branch_unit: stimulus queues expected
// post-edge state, a monitor compares it once the edge has happened.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, stall, branch_en, use_lut, lut_we, call, ret;
  logic [11:0] start_addr, lut_wdata;
  logic [3:0]  sel, lut_waddr;
  logic [11:0] pc;
  logic        running, done, ras_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    string       name;
    logic [11:0] pc;
    logic        run;
    logic        done;
    logic        err;
  } exp_t;

  exp_t q[$];

  pc_branch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .halt       (halt),
    .stall      (stall),
    .branch_en  (branch_en),
    .use_lut    (use_lut),
    .sel        (sel),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .call       (call),
    .ret        (ret),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .ras_err    (ras_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={pc,run,done,err}=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clr();
    start = 0; halt = 0; stall = 0; branch_en = 0; use_lut = 0; lut_we = 0;
    call = 0; ret = 0; start_addr = '0; lut_wdata = '0; sel = '0; lut_waddr = '0;
  endtask

  // Queue the state expected after the coming edge, then let that edge happen.
  task automatic issue(input string name, input logic [11:0] epc,
                       input logic er, input logic ed, input logic ee);
    exp_t e;
    e.due = cyc + 1; e.name = name; e.pc = epc; e.run = er; e.done = ed; e.err = ee;
    q.push_back(e);
    @(posedge clk);
    #1;
    clr();
  endtask

  // Monitor: compares queued expectations well after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) chk({e.name, "_late"}, 32'(cyc), 32'(e.due));
        else chk(e.name, {pc, running, done, ras_err}, {e.pc, e.run, e.done, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {pc, running, done, ras_err}, {12'h000, 3'b000});
    rst_n = 1'b1;
    issue("idle_hold", 12'h000, 0, 0, 0);

    start = 1; start_addr = 12'h010; issue("start", 12'h010, 1, 0, 0);
    issue("seq1", 12'h011, 1, 0, 0);
    issue("seq2", 12'h012, 1, 0, 0);
    issue("seq3", 12'h013, 1, 0, 0);

    start = 1; start_addr = 12'h020; issue("restart", 12'h020, 1, 0, 0);
    branch_en = 1; sel = 4'b1000; issue("imm_neg", 12'h018, 1, 0, 0);
    start = 1; start_addr = 12'h020; issue("restart2", 12'h020, 1, 0, 0);
    branch_en = 1; sel = 4'b0111; issue("imm_pos", 12'h027, 1, 0, 0);

    start = 1; start_addr = 12'h100; issue("start_100", 12'h100, 1, 0, 0);
    lut_we = 1; lut_waddr = 4'd13; lut_wdata = 12'hF76;
    branch_en = 1; use_lut = 1; sel = 4'd13; issue("lut_collide", 12'h100, 1, 0, 0);
    branch_en = 1; use_lut = 1; sel = 4'd13; issue("lut_branch", 12'h076, 1, 0, 0);

    start = 1; start_addr = 12'hFFF; issue("start_fff", 12'hFFF, 1, 0, 0);
    issue("wrap_inc", 12'h000, 1, 0, 0);
    start = 1; start_addr = 12'h005; issue("start_005", 12'h005, 1, 0, 0);
    branch_en = 1; sel = 4'b1000; issue("wrap_neg", 12'hFFD, 1, 0, 0);
    stall = 1; branch_en = 1; sel = 4'd7; issue("stall_br", 12'hFFD, 1, 0, 0);
    halt = 1; stall = 1; issue("halt_stall", 12'hFFD, 0, 1, 0);
    branch_en = 1; sel = 4'd3; issue("halted_hold", 12'hFFD, 0, 1, 0);
    start = 1; start_addr = 12'h200; issue("halt_restart", 12'h200, 1, 0, 0);
    start = 1; halt = 1; start_addr = 12'h300; issue("start_over_halt", 12'h300, 1, 0, 0);

    halt = 1; issue("halt", 12'h300, 0, 1, 0);
    lut_we = 1; lut_waddr = 4'd2; lut_wdata = 12'h010; issue("lut_wr_halted", 12'h300, 0, 1, 0);
    start = 1; start_addr = 12'h050; issue("start_050", 12'h050, 1, 0, 0);
    branch_en = 1; use_lut = 1; sel = 4'd2; issue("lut_halt_wr", 12'h060, 1, 0, 0);

`ifdef PC_RAS_EN
    start = 1; start_addr = 12'h040; issue("start_040", 12'h040, 1, 0, 0);
    call = 1; sel = 4'd5; issue("call", 12'h045, 1, 0, 0);
    ret = 1; issue("ret", 12'h041, 1, 0, 0);
    ret = 1; issue("ret_empty", 12'h042, 1, 0, 1);
    start = 1; start_addr = 12'h000; issue("start_clr_err", 12'h000, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      call = 1; sel = 4'd1; issue("call_fill", 12'(i), 1, 0, 0);
    end
    call = 1; sel = 4'd1; issue("call_ovf", 12'h005, 1, 0, 1);
    for (int i = 5; i >= 2; i--) begin
      ret = 1; issue("ret_drain", 12'(i), 1, 0, 1);
    end
    ret = 1; issue("ret_oldest_lost", 12'h003, 1, 0, 1);
    start = 1; start_addr = 12'h040; issue("start_040b", 12'h040, 1, 0, 0);
    call = 1; sel = 4'd1; issue("call1", 12'h041, 1, 0, 0);
    call = 1; ret = 1; sel = 4'd5; issue("call_ret", 12'h041, 1, 0, 0);
    ret = 1; issue("ret_after_cr", 12'h042, 1, 0, 1);
`else
    call = 1; sel = 4'd3; issue("call_as_br", 12'h063, 1, 0, 0);
    ret = 1; issue("ret_ignored", 12'h064, 1, 0, 0);
    ret = 1; branch_en = 1; sel = 4'd2; issue("ret_br", 12'h066, 1, 0, 0);
`endif

    start = 1; start_addr = 12'h123; issue("start_123", 12'h123, 1, 0, 0);
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {pc, running, done, ras_err}, {12'h000, 3'b000});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1; start_addr = 12'h100; issue("post_rst_start", 12'h100, 1, 0, 0);
    branch_en = 1; use_lut = 1; sel = 4'd13; issue("lut13_cleared", 12'h100, 1, 0, 0);
    branch_en = 1; use_lut = 1; sel = 4'd2; issue("lut2_cleared", 12'h100, 1, 0, 0);

    repeat (3) @(posedge clk);
    #4;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
